// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC mux (SEQ/JUMP/BRANCH/JR/CALL/RET),
// a circular return-address stack, and single-cycle error pulses.
module pc_unit #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     sel,
  input  logic [15:0]                    immediate,
  input  logic [25:0]                    jump_address,
  input  logic [WIDTH-1:0]               reg_rs,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_plus4,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_overflow,
  output logic                           ras_underflow,
  output logic                           align_err,
  output logic                           illegal_sel
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = $clog2(RAS_DEPTH);

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_JUMP   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JR     = 3'd3,
    SEL_CALL   = 3'd4,
    SEL_RET    = 3'd5
  } sel_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;   // next free slot; newest entry sits one below
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, aln_q, aln_d, ill_q, ill_d;
  logic             push;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [PW-1:0]    top_inc, top_dec;
  logic [WIDTH-1:0] jump_target, branch_offset, ras_top;

  assign pc_plus4      = pc_q + WIDTH'(4);
  assign jump_target   = {pc_plus4[WIDTH-1:28], jump_address, 2'b00};
  assign branch_offset = {{(WIDTH-18){immediate[15]}}, immediate, 2'b00};

  // Explicit wrap keeps the stack circular for non-power-of-two depths.
  assign top_inc = (top_q == PW'(RAS_DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec = (top_q == '0) ? PW'(RAS_DEPTH - 1) : top_q - PW'(1);
  assign ras_top = ras_mem[top_dec];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    aln_d = 1'b0;
    ill_d = 1'b0;
    if (!stall) begin
      case (sel)
        SEL_SEQ:    pc_d = pc_plus4;
        SEL_JUMP:   pc_d = jump_target;
        SEL_BRANCH: pc_d = pc_plus4 + branch_offset;
        SEL_JR: begin
          pc_d  = reg_rs;
          aln_d = |reg_rs[1:0];
        end
        SEL_CALL: begin
          pc_d  = jump_target;
          push  = 1'b1;
          top_d = top_inc;
          if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;
          else                         cnt_d = cnt_q + CW'(1);
        end
        SEL_RET: begin
          if (cnt_q == '0) begin
            pc_d  = reg_rs;
            unf_d = 1'b1;
          end else begin
            pc_d  = ras_top;
            top_d = top_dec;
            cnt_d = cnt_q - CW'(1);
          end
          aln_d = |pc_d[1:0];
        end
        default: begin
          pc_d  = pc_plus4;
          ill_d = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      aln_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      aln_q <= aln_d;
      ill_q <= ill_d;
    end
  end

  // NOTE: stack storage has no reset; its contents are only read while ras_count is non-zero.
  always_ff @(posedge clk) begin
    if (!reset && push) ras_mem[top_q] <= pc_plus4;
  end

  assign pc            = pc_q;
  assign ras_count     = cnt_q;
  assign ras_empty     = (cnt_q == '0);
  assign ras_full      = (cnt_q == CW'(RAS_DEPTH));
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign align_err     = aln_q;
  assign illegal_sel   = ill_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed steps push hand-computed expectations,
// a monitor pops one per clock edge and compares all outputs.
module tb_pc_unit;

  localparam logic [2:0] SEQ = 3'd0, JMP = 3'd1, BR = 3'd2, JR = 3'd3,
                         CALL = 3'd4, RET = 3'd5, ILL = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stall = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] immediate = '0;
  logic [25:0] jump_address = '0;
  logic [31:0] reg_rs = '0;
  logic [31:0] pc, pc_plus4;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow, align_err, illegal_sel;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [3:0]  flags;   // {overflow, underflow, align_err, illegal_sel}
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .sel           (sel),
    .immediate     (immediate),
    .jump_address  (jump_address),
    .reg_rs        (reg_rs),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .align_err     (align_err),
    .illegal_sel   (illegal_sel)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after the next edge.
  task automatic step(input string nm, input logic rst, input logic stl, input logic [2:0] s,
                      input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] rs,
                      input logic [31:0] epc, input logic [2:0] ecnt, input logic [3:0] eflags);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; sel = s; immediate = imm; jump_address = ja; reg_rs = rs;
    e.name = nm; e.pc = epc; e.cnt = ecnt; e.flags = eflags;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"},       pc,                e.pc);
        check({e.name, ".pc_plus4"}, pc_plus4,          e.pc + 32'd4);
        check({e.name, ".count"},    {29'd0, ras_count}, {29'd0, e.cnt});
        check({e.name, ".empty"},    {31'd0, ras_empty}, {31'd0, e.cnt == 3'd0});
        check({e.name, ".full"},     {31'd0, ras_full},  {31'd0, e.cnt == 3'd4});
        check({e.name, ".flags"},
              {28'd0, ras_overflow, ras_underflow, align_err, illegal_sel}, {28'd0, e.flags});
      end
    end
  end

  initial begin : stimulus
    // Reset and sequential flow
    step("reset",   1, 0, SEQ, 16'h0, 26'h0, 32'h0, 32'h0, 3'd0, 4'b0000);
    step("seq1",    0, 0, SEQ, 16'h0, 26'h0, 32'h0, 32'h4, 3'd0, 4'b0000);
    step("seq2",    0, 0, SEQ, 16'h0, 26'h0, 32'h0, 32'h8, 3'd0, 4'b0000);
    step("seq3",    0, 0, SEQ, 16'h0, 26'h0, 32'h0, 32'hC, 3'd0, 4'b0000);
    // Branch sign extension
    step("jr1000",  0, 0, JR,  16'h0,    26'h0, 32'h1000, 32'h1000, 3'd0, 4'b0000);
    step("br_neg",  0, 0, BR,  16'hFFFF, 26'h0, 32'h0,    32'h1000, 3'd0, 4'b0000);
    step("br_pos",  0, 0, BR,  16'h0003, 26'h0, 32'h0,    32'h1010, 3'd0, 4'b0000);
    // Jump keeps the upper nibble of pc_plus4; SEQ wraps at 2^32
    step("jrA",     0, 0, JR,  16'h0, 26'h0,  32'hA000_0000, 32'hA000_0000, 3'd0, 4'b0000);
    step("jump",    0, 0, JMP, 16'h0, 26'h40, 32'h0,         32'hA000_0100, 3'd0, 4'b0000);
    step("jrtop",   0, 0, JR,  16'h0, 26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 3'd0, 4'b0000);
    step("wrap",    0, 0, SEQ, 16'h0, 26'h0,  32'h0,         32'h0,         3'd0, 4'b0000);
    // Five calls into a four-deep stack, then five returns
    step("jr2000",  0, 0, JR,   16'h0, 26'h0,   32'h2000, 32'h2000, 3'd0, 4'b0000);
    step("call1",   0, 0, CALL, 16'h0, 26'h400, 32'h0,    32'h1000, 3'd1, 4'b0000);
    step("call2",   0, 0, CALL, 16'h0, 26'h500, 32'h0,    32'h1400, 3'd2, 4'b0000);
    step("call3",   0, 0, CALL, 16'h0, 26'h600, 32'h0,    32'h1800, 3'd3, 4'b0000);
    step("call4",   0, 0, CALL, 16'h0, 26'h700, 32'h0,    32'h1C00, 3'd4, 4'b0000);
    step("call5",   0, 0, CALL, 16'h0, 26'h800, 32'h0,    32'h2000, 3'd4, 4'b1000);
    step("ret1",    0, 0, RET,  16'h0, 26'h0,   32'h3000, 32'h1C04, 3'd3, 4'b0000);
    step("ret2",    0, 0, RET,  16'h0, 26'h0,   32'h3000, 32'h1804, 3'd2, 4'b0000);
    step("ret3",    0, 0, RET,  16'h0, 26'h0,   32'h3000, 32'h1404, 3'd1, 4'b0000);
    step("ret4",    0, 0, RET,  16'h0, 26'h0,   32'h3000, 32'h1004, 3'd0, 4'b0000);
    step("ret5",    0, 0, RET,  16'h0, 26'h0,   32'h3000, 32'h3000, 3'd0, 4'b0100);
    // Stall holds pc and stack even with CALL selected; reset beats stall
    step("call6",   0, 0, CALL, 16'h0, 26'h10, 32'h0, 32'h40, 3'd1, 4'b0000);
    step("stall1",  0, 1, CALL, 16'h0, 26'h20, 32'h0, 32'h40, 3'd1, 4'b0000);
    step("stall2",  0, 1, CALL, 16'h0, 26'h20, 32'h0, 32'h40, 3'd1, 4'b0000);
    step("stall3",  0, 1, CALL, 16'h0, 26'h20, 32'h0, 32'h40, 3'd1, 4'b0000);
    step("rst_stl", 1, 1, CALL, 16'h0, 26'h20, 32'h0, 32'h0,  3'd0, 4'b0000);
    // Misaligned JR and illegal select pulse for exactly one cycle
    step("jr_mis",  0, 0, JR,  16'h0, 26'h0, 32'h102, 32'h102, 3'd0, 4'b0010);
    step("illegal", 0, 0, ILL, 16'h0, 26'h0, 32'h0,   32'h106, 3'd0, 4'b0001);
    step("seq_end", 0, 0, SEQ, 16'h0, 26'h0, 32'h0,   32'h10A, 3'd0, 4'b0000);

    repeat (3) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the single-cycle/multicycle CPU datapath. It holds the PC register and computes the next PC from one of several sources: sequential, jump, branch, register, call and return. It adds a synchronous stall, a return-address stack (RAS) of configurable depth for call/return, and error flags. It sits between the control unit (mode select, stall) and the instruction memory address port.

## Interface
- WIDTH, 32, PC width in bits; must be ≥ 32.
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, RAS entries; must be ≥ 2.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS this cycle.
- sel  in  3  next-PC mode: 0 SEQ, 1 JUMP, 2 BRANCH, 3 JR, 4 CALL, 5 RET, 6/7 illegal.
- immediate  in  16  branch offset in words, signed.
- jump_address  in  26  jump target field.
- reg_rs  in  WIDTH  register-indirect target.
- pc  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc + 4 mod 2^WIDTH, combinational from pc.
- ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries, registered.
- ras_empty / ras_full  out  1 each  ras_count == 0 / ras_count == RAS_DEPTH.
- ras_overflow  out  1  one-cycle pulse: CALL executed while full.
- ras_underflow  out  1  one-cycle pulse: RET executed while empty.
- align_err  out  1  one-cycle pulse: JR/RET target with bits [1:0] ≠ 0.
- illegal_sel  out  1  one-cycle pulse: sel 6 or 7 executed.

## Operation
- Next-PC targets (all arithmetic mod 2^WIDTH):
  - SEQ: pc_plus4.
  - JUMP: {pc_plus4[WIDTH-1:28], jump_address, 2'b00}.
  - BRANCH: pc_plus4 + (sign_extend(immediate) << 2). Sign extension is mandatory; a zero-extended offset is a bug.
  - JR: reg_rs, used unmodified.
  - CALL: target as JUMP; pushes pc_plus4 onto the RAS.
  - RET: pops the RAS top and uses it as target. When the RAS is empty, the target is reg_rs, ras_underflow pulses, and the count stays 0.
  - Illegal: behaves as SEQ; illegal_sel pulses.
- RAS is circular, LIFO.
  - CALL when full: the oldest entry is overwritten, ras_count stays RAS_DEPTH, and ras_overflow pulses.
  - Subsequent RETs return the newest RAS_DEPTH addresses in reverse push order.
- align_err is flagged only; the misaligned target is still loaded into pc.
- Stall:
  - pc, RAS contents and ras_count hold.
  - All pulse outputs are 0 next cycle.
  - sel and operands are ignored.
- Reset:
  - pc = RESET_PC, ras_count = 0, all pulse flags 0.
  - RAS data is don't-care.
  - Reset takes priority over stall and any sel, including mid call/return sequences.
- No state machine beyond the PC register, RAS pointer/count and flag registers. Each cycle is exactly one of RESET, STALL or ADVANCE(sel).

## Timing
- Inputs are sampled at the rising edge. pc holds the selected target after that edge, so next-PC latency is 1 cycle.
- pc_plus4 and ras_empty/ras_full follow pc/ras_count combinationally, with no added latency.
- Push (CALL) and pop (RET) complete at the same edge as the PC update. A RET in the cycle immediately after a CALL returns that CALL's pc_plus4.
- Pulse flags are registered: high for exactly the one cycle after the offending edge, then low unless re-triggered.
- Back-to-back CALL/RET every cycle is supported with no bubbles.
- Deasserting reset: the first edge with reset=0 and stall=0 advances from RESET_PC.

## Test plan
- Reset, then 3 SEQ cycles: pc = 0, 4, 8, 0xC; flags 0, ras_empty=1.
- pc=0x1000 with BRANCH, imm=0xFFFF: pc=0x1000. Then BRANCH, imm=0x0003: pc=0x1010. Checks sign extension.
- pc=0xA0000000 with JUMP, jump_address=0x0000040: pc=0xA0000100. Repeat with pc=0xFFFFFFFC and SEQ: pc wraps to 0.
- RAS_DEPTH=4: 5 CALLs from distinct PCs, then 5 RETs.
  - 5th CALL: ras_overflow pulse, ras_count stays 4.
  - First 4 RETs: return the 2nd–5th call sites' +4 in reverse order.
  - 5th RET: ras_underflow pulse, pc=reg_rs.
- stall=1 for 3 cycles with sel=CALL: pc and ras_count unchanged, no pulses. Then reset asserted together with stall=1: pc=RESET_PC, ras_count=0.
- JR with reg_rs=0x102: pc=0x102, align_err pulses for 1 cycle. sel=7: pc advances by 4, illegal_sel pulses.
